instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline; produces the IF/ID register (pc, instruction) consumed by decode.
//  Holds the PC and an internal word-addressed instruction memory, loadable through a program-load port.
//  Supports stall, branch/jump redirect with flush, a global step enable and HALT detection.
// PARAMETERS
//  ADDR_BITS      32          PC / address width in bits
//  DATA_WIDTH     32          instruction width in bits
//  IMEM_ADDR_BITS 8           log2 of instruction memory depth in words (256 words)
//  HALT_WORD      32'hFFFFFFFF  encoding of the HALT instruction
// PORTS
//  clk             in   1               rising-edge clock
//  reset           in   1               asynchronous, active-high reset
//  enable          in   1               step enable; 0 freezes PC, IF/ID regs and halted
//  stall           in   1               hazard stall; hold PC and IF/ID regs
//  redirect        in   1               branch taken or jump; load redirect_target and flush
//  redirect_target in   ADDR_BITS       byte address of the next instruction
//  prog_we         in   1               program-load write strobe
//  prog_addr       in   IMEM_ADDR_BITS  word index for the program-load write
//  prog_data       in   DATA_WIDTH      instruction word to write
//  pc_out          out  ADDR_BITS       IF/ID: PC+4 of inst_out (next-PC seen by decode)
//  inst_out        out  DATA_WIDTH      IF/ID: fetched instruction; 0 (NOP) when not valid
//  valid_out       out  1               IF/ID: inst_out holds a real fetched instruction
//  pc_current      out  ADDR_BITS       live PC register, for debug readout
//  halted          out  1               HALT has been fetched; sticky until reset
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): PC=0, pc_out=0, inst_out=0, valid_out=0, halted=0.
//    Instruction memory contents are NOT reset.
//  - Memory read is combinational: fetch_word = imem[PC[IMEM_ADDR_BITS+1:2]].
//    PC bits above the index are ignored, so out-of-range addresses wrap modulo the depth.
//  - Per-edge priority is reset > !enable > redirect > halted > stall > normal:
//    !enable   : all registers hold.
//    redirect  : PC <= {redirect_target[ADDR_BITS-1:2],2'b00}; inst_out <= 0; valid_out <= 0.
//                pc_out holds. Wins over a simultaneous stall or HALT fetch; halted is not set.
//    halted=1  : PC holds; inst_out <= 0; valid_out <= 0. Only reset clears halted.
//    stall     : PC, pc_out, inst_out and valid_out hold.
//    normal    : inst_out <= fetch_word; pc_out <= PC+4; valid_out <= 1. PC <= PC+4, wrapping modulo 2^ADDR_BITS.
//  - HALT: on a normal fetch with fetch_word==HALT_WORD:
//    * the HALT word enters IF/ID (valid_out=1) and halted <= 1;
//    * PC <= PC+4 is suppressed, so pc_current stays at the HALT address;
//    * later cycles issue NOPs, as in the halted row above.
//    A HALT fetched while stall=1 does not set halted until the fetch actually completes.
//  - Latency: the instruction at PC appears on inst_out 1 cycle after PC presents it with no stall.
//    Redirect costs exactly 1 bubble.
//  - prog_we: imem[prog_addr] <= prog_data on the clock edge, regardless of enable, stall or halted.
//    The new word is readable from the next cycle. A write to the word being fetched in the same cycle
//    returns the OLD word.
// TESTING
//  1 Load imem[0..3]=11111111,22222222,33333333,44444444; release reset, enable=1
//    -> inst_out 11111111/22222222/33333333 on cycles 1/2/3; pc_out 4/8/12.
//  2 Stall=1 for 2 cycles while inst_out=22222222
//    -> inst_out and pc_out hold for 2 cycles, pc_current stays 8; resume gives 33333333.
//  3 Redirect=1, target=0x0000000E, with stall=1 in the same cycle
//    -> next cycle inst_out=0, valid_out=0, pc_current=0x0C; following cycle inst_out=imem[3].
//  4 imem[2]=FFFFFFFF
//    -> inst_out=FFFFFFFF, valid_out=1, halted=1, pc_current=8; later cycles inst_out=0, valid_out=0, PC frozen.
//    Then assert reset mid-run -> all outputs 0 immediately, without waiting for a clock edge.
//  5 Redirect target 0x00000400 with IMEM_ADDR_BITS=8 -> fetches imem[0] (wrap).
//    Run from PC=FFFFFFFC -> next PC=0.
//  6 enable=0 for 3 cycles with prog_we writing imem[5]
//    -> no register changes; imem[5] reads back the new word once fetched.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, internal loadable instruction memory and the IF/ID register.
// Handles step enable, stall, redirect with flush and sticky HALT detection.
module instruction_fetch #(
  parameter int                    ADDR_BITS      = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    IMEM_ADDR_BITS = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD      = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [ADDR_BITS-1:0]      redirect_target,
  input  logic                      prog_we,
  input  logic [IMEM_ADDR_BITS-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0]     prog_data,
  output logic [ADDR_BITS-1:0]      pc_out,
  output logic [DATA_WIDTH-1:0]     inst_out,
  output logic                      valid_out,
  output logic [ADDR_BITS-1:0]      pc_current,
  output logic                      halted
);

  localparam int IMEM_DEPTH = 2 ** IMEM_ADDR_BITS;

  logic [DATA_WIDTH-1:0] imem_q [0:IMEM_DEPTH-1];

  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  logic [ADDR_BITS-1:0]  pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  valid_q, valid_d;
  logic                  halted_q, halted_d;

  logic [DATA_WIDTH-1:0] fetch_word_s;
  logic [ADDR_BITS-1:0]  pc_plus4_s;
  logic [ADDR_BITS-1:0]  redirect_pc_s;

  // Upper PC bits are dropped by the index, so fetches wrap modulo the memory depth.
  assign fetch_word_s  = imem_q[pc_q[IMEM_ADDR_BITS+1:2]];
  assign pc_plus4_s    = pc_q + {{(ADDR_BITS-3){1'b0}}, 3'd4};
  assign redirect_pc_s = redirect_target & {{(ADDR_BITS-2){1'b1}}, 2'b00};

  // Program-load port; contents survive reset and the read above sees the pre-edge word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      imem_q[prog_addr] <= prog_data;
    end
  end

  // Next-state selection in priority order: enable, redirect, halted, stall, normal fetch.
  always_comb begin
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (!enable) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d    = redirect_pc_s;
      inst_d  = {DATA_WIDTH{1'b0}};
      valid_d = 1'b0;
    end else if (halted_q) begin
      inst_d  = {DATA_WIDTH{1'b0}};
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      inst_d   = fetch_word_s;
      pc_out_d = pc_plus4_s;
      valid_d  = 1'b1;
      // The HALT word is delivered but the PC stays parked on its address.
      if (fetch_word_s == HALT_WORD) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_plus4_s;
      end
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= {ADDR_BITS{1'b0}};
      pc_out_q <= {ADDR_BITS{1'b0}};
      inst_q   <= {DATA_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc_out     = pc_out_q;
  assign inst_out   = inst_q;
  assign valid_out  = valid_q;
  assign pc_current = pc_q;
  assign halted     = halted_q;

endmodule
